reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumer end of the power-on reset: takes the system reset and releases per-subsystem
//  resets one stage at a time. Each stage must acknowledge readiness before the next is freed.
//  Sits directly behind the power-on reset generator; feeds clock/display/IO subsystems.
//  Also supports a soft re-run of the whole sequence on request.
// PARAMETERS
//  NUM_STAGES   4        number of sequenced reset outputs (>=1)
//  STAGE_DELAY  1000     clocks in HOLD and in each GAP before a release (>=1)
//  ACK_TIMEOUT  100000   clocks allowed in WAIT_ACK before fault (>=1)
//  CNT_W        20       timer width; must hold max(STAGE_DELAY, ACK_TIMEOUT)
// PORTS
//  clock        in   1              100 MHz system clock
//  reset        in   1              synchronous, active-high reset
//  sw_reset_req in   1              1-cycle pulse: restart the sequence
//  stage_ack    in   NUM_STAGES     per-stage "out of reset and ready" level
//  stage_reset  out  NUM_STAGES     per-stage active-high reset, registered
//  seq_busy     out  1              1 while the sequence is in progress (HOLD/WAIT_ACK/GAP)
//  seq_done     out  1              1 once every stage is released and acked
//  timeout_err  out  1              sticky: a stage failed to ack in time
//  err_stage    out  $clog2(NUM_STAGES) (min 1)  index of the stage that timed out
// BEHAVIOUR
//  Reset values: stage_reset all 1, seq_busy 1, seq_done 0, timeout_err 0, err_stage 0.
//  State on reset: HOLD, timer 0, stage index k=0.
//  Priority: reset > sw_reset_req > normal FSM.
//  States:
//  - HOLD: timer counts up. At timer==STAGE_DELAY-1, stage_reset[k] clears on that edge and
//    the FSM enters WAIT_ACK with the timer cleared. stage_reset[0] therefore falls on the
//    STAGE_DELAY-th edge after reset deasserts.
//  - WAIT_ACK: stage_ack[k] is sampled only here; acks in other states are ignored.
//    - ack==1 and k==NUM_STAGES-1 -> DONE: seq_done=1, seq_busy=0 on that edge.
//    - ack==1 otherwise -> GAP, k++, timer cleared.
//    - timer==ACK_TIMEOUT-1 with no ack -> FAULT.
//    - ack and timeout on the same cycle: ack wins.
//  - GAP: identical to HOLD, but releases stage k.
//  - DONE: all stage_reset=0. Later ack drops are ignored. Stays here until reset or sw_reset_req.
//  - FAULT: stage_reset[k] is re-asserted, stages >k stay in reset, stages <k stay released.
//    timeout_err=1, err_stage=k, seq_busy=0. Stays here until reset or sw_reset_req.
//  sw_reset_req in any state (reset low):
//    - next edge: stage_reset all 1, seq_done 0, seq_busy 1, timeout_err 0, err_stage 0.
//    - FSM goes to HOLD with timer 0 and k=0, then replays with identical timing.
//  Reset mid-operation: same outcome as sw_reset_req, and it dominates. sw_reset_req is
//    ignored while reset=1.
//  The timer never wraps: it only counts in HOLD, GAP and WAIT_ACK, and is cleared on every
//    state change.
// CONFIGURATION
//  RESET_SEQ_TIMEOUT_EN
//  - Defined: WAIT_ACK timeout and the FAULT state behave as specified above.
//  - Undefined: WAIT_ACK waits indefinitely, FAULT is unreachable, timeout_err and err_stage
//    are tied to 0, and ACK_TIMEOUT is unused.
// STRUCTURE
//  Package reset_seq_pkg holds:
//  - state typedef enum {HOLD, WAIT_ACK, GAP, DONE, FAULT};
//  - default localparams for STAGE_DELAY, ACK_TIMEOUT and CNT_W.
//  One sub-module, reset_seq_timer: CNT_W up-counter with synchronous clear, enable, and a
//  compare-to-limit terminal flag. One instance, shared by HOLD, GAP and WAIT_ACK.
//  Stage index register, output registers and FSM live in the top module.
// TESTING  (NUM_STAGES=4, STAGE_DELAY=4, ACK_TIMEOUT=16; edge n = n-th edge after reset falls)
//  1 Macro on, acks tied 1, reset high 3 cycles then low.
//    -> stage_reset[k] falls at edge 4+5k (4, 9, 14, 19); seq_done=1 and seq_busy=0 at edge 20.
//  2 Macro on, stage_ack[2] held 0.
//    -> timeout_err=1 and err_stage=2 at edge 14+16=30; stage_reset=4'b1100, seq_busy=0.
//  3 sw_reset_req pulse in DONE.
//    -> next edge: stage_reset=4'hF, seq_done=0, seq_busy=1; release timing of test 1 repeats,
//       offset from the pulse.
//  4 sw_reset_req during GAP after stage 1 is acked.
//    -> next edge: all four stages reset, k=0, HOLD; a full sequence completes afterwards.
//       Also pulse reset mid-WAIT_ACK -> same result.
//  5 Macro on, stage_ack[1] rises exactly on the cycle timer==15.
//    -> no fault; GAP entered; timeout_err stays 0.
//  6 Macro off, stage_ack[0] held 0 for 10000 cycles then set to 1.
//    -> stays in WAIT_ACK with timeout_err 0; then continues with the test 1 spacing.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        DONE     = 3'd3,
        FAULT    = 3'd4
    } seq_state_e;

    localparam int DEF_STAGE_DELAY = 1000;
    localparam int DEF_ACK_TIMEOUT = 100000;
    localparam int DEF_CNT_W       = 20;

    // Width of a stage index; a single-stage build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter shared by HOLD, GAP and WAIT_ACK: synchronous clear, enable and a
// terminal flag raised while the count equals the selected limit.
module reset_seq_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_r;

    // Count register; clear wins over enable so every state change restarts at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_limit = (count_r == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one stage at a time, each gated on the previous ack.
// Optional ack timeout / FAULT handling is enabled with `define RESET_SEQ_TIMEOUT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int IDX_W      = idx_width(NUM_STAGES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  timeout_err,
    output logic [IDX_W-1:0]      err_stage
);

    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] ACK_LIM   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic TIMEOUT_ON = 1'b1;
`else
    localparam logic TIMEOUT_ON = 1'b0;
`endif

    seq_state_e            state_r;
    seq_state_e            state_s;
    logic [IDX_W-1:0]      k_r;
    logic [IDX_W-1:0]      k_s;
    logic [NUM_STAGES-1:0] stage_reset_r;
    logic [NUM_STAGES-1:0] stage_reset_s;
    logic                  busy_r;
    logic                  busy_s;
    logic                  done_r;
    logic                  done_s;
    logic                  terr_r;
    logic                  terr_s;
    logic [IDX_W-1:0]      estg_r;
    logic [IDX_W-1:0]      estg_s;
    logic                  tmr_clr_s;
    logic                  tmr_en_s;
    logic [CNT_W-1:0]      tmr_lim_s;
    logic                  tmr_tc_s;
    logic                  ack_k_s;

    assign ack_k_s   = stage_ack[k_r];
    assign tmr_lim_s = (state_r == WAIT_ACK) ? ACK_LIM : DELAY_LIM;
    assign tmr_clr_s = sw_reset_req || (state_s != state_r);

    reset_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clr      (tmr_clr_s),
        .en       (tmr_en_s),
        .limit    (tmr_lim_s),
        .at_limit (tmr_tc_s)
    );

    // Next-state and next-output logic; a software restart overrides the whole FSM.
    always_comb begin
        state_s       = state_r;
        k_s           = k_r;
        stage_reset_s = stage_reset_r;
        busy_s        = busy_r;
        done_s        = done_r;
        terr_s        = terr_r;
        estg_s        = estg_r;
        tmr_en_s      = 1'b0;
        if (sw_reset_req) begin
            state_s       = HOLD;
            k_s           = {IDX_W{1'b0}};
            stage_reset_s = {NUM_STAGES{1'b1}};
            busy_s        = 1'b1;
            done_s        = 1'b0;
            terr_s        = 1'b0;
            estg_s        = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                HOLD, GAP: begin
                    tmr_en_s = 1'b1;
                    if (tmr_tc_s) begin
                        stage_reset_s[k_r] = 1'b0;
                        state_s            = WAIT_ACK;
                    end else begin
                        state_s = state_r;
                    end
                end
                WAIT_ACK: begin
                    // Without the timeout the timer idles here, so it can never wrap.
                    tmr_en_s = TIMEOUT_ON;
                    if (ack_k_s) begin
                        if (k_r == LAST_IDX) begin
                            state_s = DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = GAP;
                            k_s     = k_r + IDX_W'(1);
                        end
`ifdef RESET_SEQ_TIMEOUT_EN
                    end else if (tmr_tc_s) begin
                        state_s            = FAULT;
                        stage_reset_s[k_r] = 1'b1;
                        busy_s             = 1'b0;
                        terr_s             = 1'b1;
                        estg_s             = k_r;
`endif
                    end else begin
                        state_s = state_r;
                    end
                end
                DONE: begin
                    stage_reset_s = {NUM_STAGES{1'b0}};
                end
                FAULT: begin
                    state_s = FAULT;
                end
                default: begin
                    // Unreachable encoding: fall back to a full restart.
                    state_s       = HOLD;
                    k_s           = {IDX_W{1'b0}};
                    stage_reset_s = {NUM_STAGES{1'b1}};
                    busy_s        = 1'b1;
                    done_s        = 1'b0;
                    terr_s        = 1'b0;
                    estg_s        = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // State, stage index and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= HOLD;
            k_r           <= {IDX_W{1'b0}};
            stage_reset_r <= {NUM_STAGES{1'b1}};
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            terr_r        <= 1'b0;
            estg_r        <= {IDX_W{1'b0}};
        end else begin
            state_r       <= state_s;
            k_r           <= k_s;
            stage_reset_r <= stage_reset_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            terr_r        <= terr_s;
            estg_r        <= estg_s;
        end
    end

    assign stage_reset = stage_reset_r;
    assign seq_busy    = busy_r;
    assign seq_done    = done_r;
    assign timeout_err = terr_r;
    assign err_stage   = estg_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline model predicts every output change.
module tb_reset_sequencer;

    localparam int NS    = 4;
    localparam int SD    = 4;
    localparam int AT    = 16;
    localparam int NEVER = 1 << 30;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int         at;
        logic [8:0] snap;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          sw_reset_req;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_reset;
    logic          seq_busy;
    logic          seq_done;
    logic          timeout_err;
    logic [1:0]    err_stage;

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .STAGE_DELAY (SD),
        .ACK_TIMEOUT (AT),
        .CNT_W       (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw_reset_req (sw_reset_req),
        .stage_ack    (stage_ack),
        .stage_reset  (stage_reset),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .timeout_err  (timeout_err),
        .err_stage    (err_stage)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Stimulus plan for the current scenario (absolute edge numbers).
    int rst1_from, rst1_to, rst2_from, rst2_to, sw1_at, sw2_at;
    int ack_rise[NS];
    int ack_drop_e;

    // Model output state.
    logic [NS-1:0] m_sr;
    logic          m_busy, m_done, m_terr;
    logic [1:0]    m_es;
    logic [8:0]    m_snap = 'x;

    function automatic bit ack_val(input int k, input int e);
        return (e >= ack_rise[k]) && (e < ack_drop_e);
    endfunction

    task automatic emit(input int e);
        logic [8:0] p;
        ev_t ev;
        p = {m_sr, m_busy, m_done, m_terr, m_es};
        if (p !== m_snap) begin
            ev.at   = e;
            ev.snap = p;
            exp_q.push_back(ev);
        end
        m_snap = p;
    endtask

    // Timeline of one run: outputs reset at edge f, timing starts at edge s, events before stop.
    task automatic model_run(input int f, input int s, input int stop, output int last);
        int t, r, e;
        bit acked;
        m_sr = '1; m_busy = 1'b1; m_done = 1'b0; m_terr = 1'b0; m_es = 2'd0;
        emit(f);
        last = f;
        t = s;
        for (int k = 0; k < NS; k++) begin
            r = t + SD;
            if (r >= stop) return;
            m_sr[k] = 1'b0;
            emit(r);
            last  = r;
            e     = r + 1;
            acked = 1'b0;
            while (e < stop && !acked) begin
                if (ack_val(k, e)) begin
                    acked = 1'b1;
                end else if (TO_EN && e == r + AT) begin
                    m_sr[k] = 1'b1; m_busy = 1'b0; m_terr = 1'b1; m_es = 2'(k);
                    emit(e);
                    last = e;
                    return;
                end else begin
                    e++;
                end
            end
            if (!acked) return;
            last = e;
            if (k == NS - 1) begin
                m_busy = 1'b0; m_done = 1'b1;
                emit(e);
            end else begin
                t = e;
            end
        end
    endtask

    task automatic drive(input int e);
        reset        = (e >= rst1_from && e <= rst1_to) || (e >= rst2_from && e <= rst2_to);
        sw_reset_req = (e == sw1_at) || (e == sw2_at);
        for (int k = 0; k < NS; k++) stage_ack[k] = ack_val(k, e);
    endtask

    // start_kind 0 = reset for start_len cycles, 1 = sw pulse; int_kind 0 none, 1 sw, 2 reset.
    task automatic run_scenario(input int start_kind, input int start_len,
                                input int o0, input int o1, input int o2, input int o3,
                                input int int_kind, input int int_off, input int int_len);
        int b, f, s, p, s2, last, dummy, end_e;
        int offs[NS];
        offs = '{o0, o1, o2, o3};
        b = cyc;
        f = b + 1;
        rst1_from = -1; rst1_to = -2; rst2_from = -1; rst2_to = -2; sw1_at = -1; sw2_at = -1;
        if (start_kind == 0) begin
            rst1_from = f; rst1_to = b + start_len; s = b + start_len;
        end else begin
            sw1_at = f; s = f;
        end
        for (int k = 0; k < NS; k++) ack_rise[k] = (offs[k] == NEVER) ? NEVER : s + offs[k];
        ack_drop_e = NEVER;
        if (int_kind == 0) begin
            model_run(f, s, NEVER, last);
        end else begin
            p = s + int_off;
            model_run(f, s, p, dummy);
            if (int_kind == 1) begin
                sw2_at = p; s2 = p;
            end else begin
                rst2_from = p; rst2_to = p + int_len - 1; s2 = rst2_to;
            end
            model_run(p, s2, NEVER, last);
        end
        // Acks may drop once the sequence has settled; the DUT must ignore that.
        ack_drop_e = last + 1 + int'($urandom_range(0, 2));
        end_e = last + 4;
        for (int e = f; e <= end_e; e++) begin
            drive(e);
            @(negedge clock);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL missing_event: %0d predicted changes not seen, next at edge %0d value %h",
                     exp_q.size(), exp_q[0].at, exp_q[0].snap);
            exp_q.delete();
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: every change of the output vector must match the next predicted event.
    initial begin
        logic [8:0] obs;
        logic [8:0] prev = 'x;
        ev_t ev;
        forever begin
            @(negedge clock);
            obs = {stage_reset, seq_busy, seq_done, timeout_err, err_stage};
            if (obs !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: edge %0d got %h, none predicted", cyc, obs);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.at != cyc || ev.snap !== obs) begin
                        $display("FAIL output_event: got %h at edge %0d, expected %h at edge %0d",
                                 obs, cyc, ev.snap, ev.at);
                    end else begin
                        n_pass++;
                    end
                end
            end
            prev = obs;
        end
    end

    // Bound on total run length.
    always @(posedge clock) begin
        if (cyc > 90000) begin
            $display("FAIL watchdog: cycle budget exceeded at edge %0d", cyc);
            $fatal(1);
        end
    end

    initial begin
        int o[NS];
        int ik;
        reset = 1'b1; sw_reset_req = 1'b0; stage_ack = '0;
        run_scenario(0, 3, 0, 0, 0, 0, 0, 0, 0);                         // acks tied high
        run_scenario(1, 1, 0, 0, 0, 0, 0, 0, 0);                         // sw restart from DONE
        run_scenario(0, 2, 0, 0, TO_EN ? NEVER : 60, 0, 0, 0, 0);        // stage 2 silent
        run_scenario(1, 1, 0, 0, 0, 0, 0, 0, 0);                         // sw restart after it
        run_scenario(0, 1, 0, 0, 0, 0, 1, 12, 1);                        // sw in GAP after stage 1
        run_scenario(0, 1, 0, 0, 30, 0, 2, 20, 2);                       // reset mid WAIT_ACK
        run_scenario(0, 1, 0, 25, 0, 0, 0, 0, 0);                        // ack on last timer cycle
        run_scenario(0, 1, 0, 26, 0, 0, 0, 0, 0);                        // ack one cycle late
        run_scenario(0, 1, 10000, 0, 0, 0, 0, 0, 0);                     // long stall on stage 0
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < NS; k++) begin
                o[k] = $urandom_range(0, 45);
                if (TO_EN && $urandom_range(0, 9) == 0) o[k] = NEVER;
            end
            ik = $urandom_range(0, 2);
            run_scenario($urandom_range(0, 1), $urandom_range(1, 3), o[0], o[1], o[2], o[3],
                         ik, $urandom_range(1, 40), $urandom_range(1, 2));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
